// File: rtl/s2p_align.sv
// s2p_align: MSB-first serial-to-parallel front end. Hunts bit-by-bit for a sync
// word, locks after SYNC_COUNT aligned syncs, then strobes out each non-sync word.
module s2p_align #(
  parameter int unsigned     BITS       = 8,
  parameter logic [BITS-1:0] SYNC_WORD  = BITS'(8'hBC),
  parameter int unsigned     SYNC_COUNT = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            data_in,
  output logic [BITS-1:0] data_out,
  output logic            valid_out,
  output logic            active
);

  localparam int unsigned        CNT_W       = $clog2(BITS);
  localparam int unsigned        SYNC_W      = $clog2(SYNC_COUNT + 1);
  localparam logic [CNT_W-1:0]   LAST_BIT    = CNT_W'(BITS - 1);
  localparam logic [SYNC_W-1:0]  SYNC_TARGET = SYNC_W'(SYNC_COUNT);
  localparam logic [SYNC_W-1:0]  SYNC_ONE    = SYNC_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_COUNT  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nx;

  // Only BITS-1 history bits are kept; the incoming bit completes the word.
  logic [BITS-2:0]    sr;
  logic [BITS-2:0]    sr_nx;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]   bit_cnt_nx;
  logic [SYNC_W-1:0]  sync_cnt;
  logic [SYNC_W-1:0]  sync_cnt_nx;
  logic [BITS-1:0]    data_nx;
  logic               valid_nx;
  logic               active_nx;

  logic [BITS-1:0]    word;
  logic               sync_hit;
  logic               boundary;
  logic [SYNC_W-1:0]  sync_inc;

  assign word     = {sr, data_in};
  assign sync_hit = (word == SYNC_WORD);
  assign boundary = (bit_cnt == LAST_BIT);
  assign sync_inc = sync_cnt + SYNC_ONE;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_SEARCH;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: free hunt in SEARCH, word-boundary checks in COUNT.
  always_comb begin
    state_nx = state;
    case (state)
      ST_SEARCH: begin
        if (sync_hit) begin
          state_nx = (SYNC_COUNT == 1) ? ST_ACTIVE : ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (boundary) begin
          if (!sync_hit) begin
            state_nx = ST_SEARCH;
          end else if (sync_inc == SYNC_TARGET) begin
            state_nx = ST_ACTIVE;
          end
        end
      end
      ST_ACTIVE: state_nx = ST_ACTIVE;
      default:   state_nx = ST_SEARCH;
    endcase
  end

  // Datapath and output next values; outputs are registered below.
  always_comb begin
    sr_nx       = word[BITS-2:0];
    bit_cnt_nx  = boundary ? '0 : bit_cnt + CNT_ONE;
    sync_cnt_nx = sync_cnt;
    data_nx     = data_out;
    valid_nx    = 1'b0;
    active_nx   = (state_nx == ST_ACTIVE);
    case (state)
      ST_SEARCH: begin
        bit_cnt_nx  = '0;
        sync_cnt_nx = sync_hit ? SYNC_ONE : '0;
      end
      ST_COUNT: begin
        if (boundary) begin
          sync_cnt_nx = sync_hit ? sync_inc : '0;
        end
      end
      ST_ACTIVE: begin
        // Sync words in lock are idle filler: no strobe, data holds.
        if (boundary && !sync_hit) begin
          data_nx  = word;
          valid_nx = 1'b1;
        end
      end
      default: begin
        bit_cnt_nx  = '0;
        sync_cnt_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr        <= '0;
      bit_cnt   <= '0;
      sync_cnt  <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      sr        <= sr_nx;
      bit_cnt   <= bit_cnt_nx;
      sync_cnt  <= sync_cnt_nx;
      data_out  <= data_nx;
      valid_out <= valid_nx;
      active    <= active_nx;
    end
  end

endmodule

// File: tb/tb_s2p_align.sv
// tb_s2p_align: drives bit streams into s2p_align and checks every cycle against
// an array-scan model of the hunt/count/lock rules.
module tb_s2p_align;

  localparam int unsigned W    = 8;
  localparam logic [7:0]  SYNC = 8'hBC;
  localparam int          SC   = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         data_in = 1'b0;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         active;

  s2p_align #(.BITS(W), .SYNC_WORD(SYNC), .SYNC_COUNT(SC)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .data_in(data_in),
    .data_out(data_out),
    .valid_out(valid_out),
    .active(active)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit         seg[$];
  bit         exp_v[$];
  bit         exp_a[$];
  logic [7:0] exp_d[$];
  int         lock_at;
  bit         chk_en = 1'b0;
  int         cur_idx = 0;

  // Word completed at edge t: bits t-7..t, zeros before the segment start.
  function automatic logic [7:0] win(int t);
    logic [7:0] v;
    v = 8'h00;
    for (int j = 7; j >= 0; j--) begin
      v = {v[6:0], ((t - j) >= 0) ? seg[t - j] : 1'b0};
    end
    return v;
  endfunction

  // Scan the whole segment: find the lock edge, then list strobes at word steps.
  task automatic build_model();
    int n;
    int t;
    logic [7:0] hold;
    n = seg.size();
    lock_at = -1;
    t = 0;
    while (t < n && lock_at < 0) begin
      if (win(t) == SYNC) begin
        int cnt;
        int u;
        cnt = 1;
        u = t;
        while (cnt < SC && (u + 8) < n && win(u + 8) == SYNC) begin
          u += 8;
          cnt++;
        end
        if (cnt == SC) lock_at = u;
        else if ((u + 8) < n) t = u + 9;
        else t = n;
      end else begin
        t++;
      end
    end
    exp_v.delete();
    exp_a.delete();
    exp_d.delete();
    hold = 8'h00;
    for (int k = 0; k < n; k++) begin
      bit lk;
      bit v;
      lk = (lock_at >= 0) && (k >= lock_at);
      v = lk && (k > lock_at) && (((k - lock_at) % 8) == 0) && (win(k) != SYNC);
      if (v) hold = win(k);
      exp_a.push_back(lk);
      exp_v.push_back(v);
      exp_d.push_back(hold);
    end
  endtask

  function automatic int count_valid();
    int c;
    c = 0;
    foreach (exp_v[i]) if (exp_v[i]) c++;
    return c;
  endfunction

  task automatic pin(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) seg.push_back(b[i]);
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) seg.push_back(1'($urandom_range(0, 1)));
  endtask

  // Compare process: every enabled cycle, #1 after the edge.
  always @(posedge clk) begin
    int k;
    if (chk_en) begin
      k = cur_idx;
      #1;
      checks++;
      if (valid_out !== exp_v[k] || active !== exp_a[k] || data_out !== exp_d[k]) begin
        errors++;
        $display("FAIL cycle %0d: got v=%b a=%b d=%h expected v=%b a=%b d=%h",
                 k, valid_out, active, data_out, exp_v[k], exp_a[k], exp_d[k]);
      end
    end
  end

  task automatic play(input int upto);
    for (int k = 0; k < upto; k++) begin
      @(negedge clk);
      data_in = seg[k];
      cur_idx = k;
      chk_en  = 1'b1;
    end
    @(negedge clk);
    chk_en = 1'b0;
  endtask

  task automatic check_zero(input string name);
    pin({name, "_data"}, int'(data_out), 0);
    pin({name, "_valid"}, int'(valid_out), 0);
    pin({name, "_active"}, int'(active), 0);
  endtask

  // Async reset between edges, hold across one edge, release at a negedge.
  task automatic do_reset(input string name);
    #2 reset_n = 1'b0;
    data_in = 1'b0;
    #1 check_zero(name);
    @(posedge clk);
    #1 check_zero({name, "_held"});
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int n0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Lock after 3 random bits, then 5A; reset mid-stream afterwards.
    seg.delete();
    push_rand(3);
    repeat (4) push_byte(SYNC);
    push_byte(8'h5A);
    push_rand(5);
    build_model();
    pin("lock_pre", int'(exp_a[33]), 0);
    pin("lock_edge", int'(exp_a[34]), 1);
    pin("lock_5a_v", int'(exp_v[42]), 1);
    pin("lock_5a_d", int'(exp_d[42]), 8'h5A);
    play(seg.size());
    do_reset("rst_lock");

    // Broken lock through 3C, relock on the following four syncs.
    seg.delete();
    push_byte(SYNC); push_byte(SYNC); push_byte(8'h3C);
    repeat (4) push_byte(SYNC);
    push_byte(8'hA5);
    build_model();
    pin("broken_pre", int'(exp_a[54]), 0);
    pin("broken_lock", int'(exp_a[55]), 1);
    pin("broken_a5", int'(exp_d[63]), 8'hA5);
    pin("broken_nv", count_valid(), 1);
    play(seg.size());
    do_reset("rst_broken");

    // Idle filler between two data words.
    seg.delete();
    repeat (4) push_byte(SYNC);
    push_byte(8'h11); push_byte(SYNC); push_byte(8'h22);
    build_model();
    pin("idle_nv", count_valid(), 2);
    pin("idle_hold_v", int'(exp_v[47]), 0);
    pin("idle_hold_d", int'(exp_d[47]), 8'h11);
    pin("idle_22", int'(exp_d[55]), 8'h22);
    play(seg.size());
    do_reset("rst_idle");

    // Two-bit offset, then data hiding a shifted sync pattern.
    seg.delete();
    seg.push_back(1'b0); seg.push_back(1'b1);
    repeat (4) push_byte(SYNC);
    push_byte(8'hF0); push_byte(8'h5E); push_byte(8'h00);
    build_model();
    pin("offs_lock", lock_at, 33);
    pin("offs_f0", int'(exp_d[41]), 8'hF0);
    pin("offs_nv", count_valid(), 3);
    play(seg.size());
    do_reset("rst_offs");

    // Back-to-back data, reset mid-way through a further word.
    seg.delete();
    repeat (4) push_byte(SYNC);
    push_byte(8'h00); push_byte(8'hFF); push_byte(8'h80); push_byte(8'h01);
    push_byte(8'h77);
    build_model();
    pin("b2b_80", int'(exp_d[55]), 8'h80);
    pin("b2b_01", int'(exp_d[63]), 8'h01);
    pin("b2b_nv", count_valid(), 5);
    play(seg.size() - 4);
    do_reset("rst_b2b");

    // Randomized streams: random prefix, sync run, data with occasional filler.
    for (int r = 0; r < 10; r++) begin
      seg.delete();
      push_rand($urandom_range(0, 15));
      repeat (($urandom_range(0, 4) == 0) ? 3 : 4) push_byte(SYNC);
      repeat ($urandom_range(6, 12)) begin
        if ($urandom_range(0, 3) == 0) push_byte(SYNC);
        else push_byte(8'($urandom));
      end
      build_model();
      n0 = seg.size() - $urandom_range(0, 7);
      play(n0);
      do_reset("rst_rand");
    end

    // Pure noise stream.
    seg.delete();
    push_rand(300);
    build_model();
    play(seg.size());
    do_reset("rst_noise");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
